regfile_sb_param: RTL
=====================

Name: regfile_sb_param

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file.
- Generalises data width and register count.
- Adds write-to-read bypass as a build option and hardwired-zero R0 as a build option.
- Adds a per-register busy scoreboard for the pipelined datapath.
- Adds a sequential clear engine so the decode stage can flush architectural state without a global reset.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register index width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return pre-write value
ZERO_R0, 1, 1 = register 0 reads 0, ignores writes, never marked busy

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
rd_addr1  in  ADDR_W  read port 1 index
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_addr2  in  ADDR_W  read port 2 index
rd_data2  out  DATA_W  read port 2 data (combinational)
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
iss_en  in  1  issue strobe: mark iss_addr as pending write
iss_addr  in  ADDR_W  destination of issued instruction
busy1  out  1  scoreboard bit for rd_addr1 (combinational)
busy2  out  1  scoreboard bit for rd_addr2 (combinational)
clr_req  in  1  start sequential clear
ready  out  1  1 = IDLE, writes/issues accepted

Behaviour:
- Reset: rst==0 at posedge -> all registers 0, all busy bits 0, FSM to IDLE, counter 0. ready reads 1 from the first cycle after reset. rd_data* reads 0 and busy* reads 0 at any index until new writes/issues.
- Read ports: purely combinational from the array, zero latency.
- Bypass, BYPASS=1: rd_dataN = wr_data when all of the following hold:
  - state IDLE
  - wr_en=1
  - wr_addr==rd_addrN
  - not (ZERO_R0 and rd_addrN==0)
- Bypass, BYPASS=0: rd_dataN returns the array value; the new value is visible the next cycle.
- Both ports may read the same index; each port bypasses independently.
- Write: in IDLE with wr_en=1 -> reg[wr_addr] <= wr_data at posedge. Write to index 0 is dropped when ZERO_R0=1.
- R0: with ZERO_R0=1, rd_dataN = 0 whenever rd_addrN==0, regardless of bypass.
- Scoreboard, in IDLE only:
  - iss_en=1 sets busy[iss_addr].
  - wr_en=1 clears busy[wr_addr].
  - Same index, same cycle: set wins, because the new producer supersedes.
  - Different indices: both take effect.
  - With ZERO_R0=1, busy[0] stays 0.
- busyN = busy[rd_addrN], except it is forced to 0 when the bypass condition for port N is active (data is being forwarded this cycle). With BYPASS=0, busyN = busy[rd_addrN] unmodified.
- FSM states:
  - IDLE: ready=1. clr_req=1 -> CLEAR, counter <= 0.
  - CLEAR: ready=0. Each cycle reg[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1. When cnt==DEPTH-1, that final entry is cleared and the FSM goes to IDLE with cnt <= 0.
- Clear latency: ready is low for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
- During CLEAR:
  - wr_en and iss_en are ignored; no write, no scoreboard change.
  - Bypass is disabled.
  - Reads return the live array, so they can show partially cleared state.
  - clr_req is ignored; there is no restart.
- clr_req and wr_en in the same IDLE cycle: the write is performed and the clear starts next cycle, so the written value is later zeroed.
- rst low mid-CLEAR: the next state is IDLE with everything zero, regardless of cnt.
- Counter width ADDR_W; wrap from DEPTH-1 to 0 ends the clear.

Test Plan:
- Reset then read all: rst=0 one cycle, rst=1; sweep rd_addr1/2 over 0..15 -> rd_data*=0x0000, busy*=0, ready=1.
- Write/bypass: BYPASS=1, wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr1=5 in the same cycle -> rd_data1=0xBEEF that cycle. BYPASS=0 build -> 0x0000 that cycle, 0xBEEF the next.
- R0: wr_en=1, wr_addr=0, wr_data=0x1234; iss_en=1, iss_addr=0 -> rd_data1(addr 0)=0x0000 in the same and all later cycles, busy1=0.
- Scoreboard: iss_en addr 7 -> busy1(addr 7)=1 next cycle. Then wr_en addr 7 with iss_en addr 7 in the same cycle -> busy stays 1. Then wr_en addr 7 alone, data 0x00AA -> busy1=0 during the write cycle (bypass) and after; rd_data1=0x00AA.
- Clear: write 0xFFFF to regs 1..15, pulse clr_req -> ready=0 for exactly 16 cycles. A wr_en to reg 3 during CLEAR is ignored; all regs read 0 after ready returns to 1.
- Reset mid-clear: assert rst=0 at CLEAR cycle 6 -> the next cycle is IDLE, ready=1, all registers and busy bits 0.

Source files
------------

// File: rtl/regfile_sb_param.sv
// ============================================================================
// regfile_sb_param : parametrised 2R/1W register file, busy scoreboard, clear engine
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_sb_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              busy1,
   output logic              busy2,
   input  logic              clr_req,
   output logic              ready
);

   localparam int                c_DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] c_LAST  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] c_ZERO  = '0;

   localparam logic [0:0] c_IDLE  = 1'b0;
   localparam logic [0:0] c_CLEAR = 1'b1;

   logic [DATA_W-1:0]  r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_busy;
   logic [c_DEPTH-1:0] w_busy_nxt;
   logic [0:0]         r_state;
   logic [ADDR_W-1:0]  r_cnt;

   logic w_idle;
   logic w_wr_ok;
   logic w_r0_1;
   logic w_r0_2;
   logic w_byp1;
   logic w_byp2;

   assign w_idle  = (r_state == c_IDLE);
   assign w_wr_ok = w_idle && wr_en && !((ZERO_R0 != 0) && (wr_addr == c_ZERO));
   assign ready   = w_idle;

   // Forwarding only exists while the write port is live (IDLE) and never for a hardwired R0
   assign w_r0_1 = (ZERO_R0 != 0) && (rd_addr1 == c_ZERO);
   assign w_r0_2 = (ZERO_R0 != 0) && (rd_addr2 == c_ZERO);
   assign w_byp1 = (BYPASS != 0) && w_idle && wr_en && (wr_addr == rd_addr1) && !w_r0_1;
   assign w_byp2 = (BYPASS != 0) && w_idle && wr_en && (wr_addr == rd_addr2) && !w_r0_2;

   always_comb begin
      rd_data1 = r_mem[rd_addr1];
      if (w_r0_1) begin
         rd_data1 = '0;
      end else if (w_byp1) begin
         rd_data1 = wr_data;
      end
   end

   always_comb begin
      rd_data2 = r_mem[rd_addr2];
      if (w_r0_2) begin
         rd_data2 = '0;
      end else if (w_byp2) begin
         rd_data2 = wr_data;
      end
   end

   assign busy1 = w_byp1 ? 1'b0 : r_busy[rd_addr1];
   assign busy2 = w_byp2 ? 1'b0 : r_busy[rd_addr2];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (!w_idle) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Issue is applied after the write-clear so a new producer supersedes a retiring one
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_idle) begin
         if (wr_en) begin
            w_busy_nxt[wr_addr] = 1'b0;
         end
         if (iss_en) begin
            w_busy_nxt[iss_addr] = 1'b1;
         end
      end else begin
         w_busy_nxt[r_cnt] = 1'b0;
      end
      if (ZERO_R0 != 0) begin
         w_busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (clr_req) begin
                  r_state <= c_CLEAR;
                  r_cnt   <= '0;
               end
            end
            c_CLEAR: begin
               if (r_cnt == c_LAST) begin
                  r_state <= c_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
